// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer
// Sequences the INTA# pulse train for the 8259A. It tracks READY/ACK1/ACK2/ACK3,
// latches the acknowledged one-hot level at ACK1, and drives the vector/CALL
// bytes. At the end of a sequence it emits a completion pulse and an optional
// automatic-EOI pulse.
// Optional feature macro: MCS80_MODE_EN. When it is defined, the three-pulse
// MCS-80/85 sequence is available. When it is undefined, only the 8086
// two-pulse sequence exists.
module interrupt_ack_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_acknowledge_n,
  input  logic [7:0]  highest_request,
  input  logic        u8086_or_mcs80_config,
  input  logic [4:0]  vector_base,
  input  logic [10:0] call_address,
  input  logic        call_interval_4_config,
  input  logic        auto_eoi_config,
  input  logic        cascade_output_ack_2_3,
  output logic [2:0]  control_state,
  output logic [7:0]  acknowledge_interrupt,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_enable,
  output logic        end_of_acknowledge_sequence,
  output logic        auto_eoi_clear
);

  typedef enum logic [2:0] {
    READY = 3'b000,
    ACK1  = 3'b001,
    ACK2  = 3'b010,
    ACK3  = 3'b011
  } state_t;

  state_t      state_r;
  logic        inta_prev_r;
  logic        mode_r;        // 1 = 8086, 0 = MCS-80/85, frozen at ACK1
  logic [7:0]  ack_r;
  logic        end_r;
  logic        eoi_r;
  logic        fall_s;
  logic        rise_s;
  logic        mode_sel_s;
  logic [2:0]  num_s;
  logic [7:0]  bus_byte_s;
  logic        bus_en_s;

  // Binary index of a one-hot level. The latch is always one-hot or zero.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef MCS80_MODE_EN
  assign mode_sel_s = u8086_or_mcs80_config;
`else
  // Without MCS-80 support, the mode input and the CALL-address inputs have no
  // function.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{u8086_or_mcs80_config, call_address, call_interval_4_config};
  assign mode_sel_s   = 1'b1;
`endif

  assign fall_s = inta_prev_r & ~interrupt_acknowledge_n;
  assign rise_s = ~inta_prev_r & interrupt_acknowledge_n;
  assign num_s  = onehot_to_index(ack_r);

  // Acknowledge FSM: edge tracking, level latch, mode freeze and end-of-sequence pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= READY;
      inta_prev_r <= 1'b1;
      mode_r      <= 1'b1;
      ack_r       <= 8'h00;
      end_r       <= 1'b0;
      eoi_r       <= 1'b0;
    end else begin
      inta_prev_r <= interrupt_acknowledge_n;
      end_r       <= 1'b0;
      eoi_r       <= 1'b0;
      case (state_r)
        READY: begin
          if (fall_s) begin
            state_r <= ACK1;
            ack_r   <= (highest_request == 8'h00) ? 8'h80 : highest_request;
            mode_r  <= mode_sel_s;
          end else begin
            state_r <= READY;
          end
        end
        ACK1: begin
          if (fall_s) begin
            state_r <= ACK2;
          end else begin
            state_r <= ACK1;
          end
        end
        ACK2: begin
          if (rise_s && mode_r) begin
            state_r <= READY;
            end_r   <= 1'b1;
            eoi_r   <= auto_eoi_config;
          end else if (fall_s && !mode_r) begin
            state_r <= ACK3;
          end else begin
            state_r <= ACK2;
          end
        end
        ACK3: begin
          if (rise_s) begin
            state_r <= READY;
            end_r   <= 1'b1;
            eoi_r   <= auto_eoi_config;
          end else begin
            state_r <= ACK3;
          end
        end
        default: begin
          state_r <= READY;
        end
      endcase
    end
  end

  // Byte selection and drive permission for the current acknowledge pulse.
  always_comb begin
    bus_byte_s = 8'h00;
    bus_en_s   = 1'b0;
    if (!interrupt_acknowledge_n && (state_r != READY)) begin
      case (state_r)
        ACK1: begin
`ifdef MCS80_MODE_EN
          // The CALL opcode comes from the master, so it does not need cascade permission.
          if (!mode_r) begin
            bus_byte_s = 8'hCD;
            bus_en_s   = 1'b1;
          end else begin
            bus_byte_s = 8'h00;
            bus_en_s   = 1'b0;
          end
`else
          bus_byte_s = 8'h00;
          bus_en_s   = 1'b0;
`endif
        end
        ACK2: begin
          if (cascade_output_ack_2_3) begin
            bus_en_s = 1'b1;
`ifdef MCS80_MODE_EN
            if (mode_r) begin
              bus_byte_s = {vector_base, num_s};
            end else if (call_interval_4_config) begin
              bus_byte_s = {call_address[2:0], num_s, 2'b00};
            end else begin
              bus_byte_s = {call_address[2:1], num_s, 3'b000};
            end
`else
            bus_byte_s = {vector_base, num_s};
`endif
          end else begin
            bus_byte_s = 8'h00;
            bus_en_s   = 1'b0;
          end
        end
        ACK3: begin
`ifdef MCS80_MODE_EN
          if (cascade_output_ack_2_3) begin
            bus_byte_s = call_address[10:3];
            bus_en_s   = 1'b1;
          end else begin
            bus_byte_s = 8'h00;
            bus_en_s   = 1'b0;
          end
`else
          bus_byte_s = 8'h00;
          bus_en_s   = 1'b0;
`endif
        end
        default: begin
          bus_byte_s = 8'h00;
          bus_en_s   = 1'b0;
        end
      endcase
    end else begin
      bus_byte_s = 8'h00;
      bus_en_s   = 1'b0;
    end
  end

  assign control_state               = state_r;
  assign acknowledge_interrupt       = ack_r;
  assign data_bus_enable             = bus_en_s;
  assign data_bus_out                = bus_en_s ? bus_byte_s : 8'h00;
  assign end_of_acknowledge_sequence = end_r;
  assign auto_eoi_clear              = eoi_r;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed self-checking bench for interrupt_ack_sequencer.
module tb_interrupt_ack_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        interrupt_acknowledge_n = 1'b1;
  logic [7:0]  highest_request = 8'h00;
  logic        u8086_or_mcs80_config = 1'b1;
  logic [4:0]  vector_base = 5'h00;
  logic [10:0] call_address = 11'h000;
  logic        call_interval_4_config = 1'b1;
  logic        auto_eoi_config = 1'b0;
  logic        cascade_output_ack_2_3 = 1'b1;
  logic [2:0]  control_state;
  logic [7:0]  acknowledge_interrupt;
  logic [7:0]  data_bus_out;
  logic        data_bus_enable;
  logic        end_of_acknowledge_sequence;
  logic        auto_eoi_clear;

  int tests_run = 0;
  int tests_failed = 0;

  interrupt_ack_sequencer dut (
    .clock(clock),
    .reset(reset),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .highest_request(highest_request),
    .u8086_or_mcs80_config(u8086_or_mcs80_config),
    .vector_base(vector_base),
    .call_address(call_address),
    .call_interval_4_config(call_interval_4_config),
    .auto_eoi_config(auto_eoi_config),
    .cascade_output_ack_2_3(cascade_output_ack_2_3),
    .control_state(control_state),
    .acknowledge_interrupt(acknowledge_interrupt),
    .data_bus_out(data_bus_out),
    .data_bus_enable(data_bus_enable),
    .end_of_acknowledge_sequence(end_of_acknowledge_sequence),
    .auto_eoi_clear(auto_eoi_clear)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs and samples sit 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic inta_low();
    interrupt_acknowledge_n = 1'b0;
    tick();
  endtask

  task automatic inta_high();
    interrupt_acknowledge_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL reset_state got %b expected 000", control_state); end
    tests_run++; if (acknowledge_interrupt !== 8'h00) begin tests_failed++; $display("FAIL reset_latch got %h expected 00", acknowledge_interrupt); end
    tests_run++; if (data_bus_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_enable got %b expected 0", data_bus_enable); end
    tests_run++; if (data_bus_out !== 8'h00) begin tests_failed++; $display("FAIL reset_bus got %h expected 00", data_bus_out); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b0) begin tests_failed++; $display("FAIL reset_end got %b expected 0", end_of_acknowledge_sequence); end
    tests_run++; if (auto_eoi_clear !== 1'b0) begin tests_failed++; $display("FAIL reset_eoi got %b expected 0", auto_eoi_clear); end
  endtask

  task automatic test_8086();
    highest_request = 8'h08; vector_base = 5'h11; cascade_output_ack_2_3 = 1'b1;
    auto_eoi_config = 1'b0; u8086_or_mcs80_config = 1'b1;
    inta_low();
    tests_run++; if (control_state !== 3'b001) begin tests_failed++; $display("FAIL x86_ack1_state got %b expected 001", control_state); end
    tests_run++; if (data_bus_enable !== 1'b0) begin tests_failed++; $display("FAIL x86_ack1_enable got %b expected 0", data_bus_enable); end
    tests_run++; if (acknowledge_interrupt !== 8'h08) begin tests_failed++; $display("FAIL x86_latch got %h expected 08", acknowledge_interrupt); end
    inta_high();
    tests_run++; if (control_state !== 3'b001) begin tests_failed++; $display("FAIL x86_rise_ack1 got %b expected 001", control_state); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b0) begin tests_failed++; $display("FAIL x86_no_end_ack1 got %b expected 0", end_of_acknowledge_sequence); end
    inta_low();
    tests_run++; if (control_state !== 3'b010) begin tests_failed++; $display("FAIL x86_ack2_state got %b expected 010", control_state); end
    tests_run++; if (data_bus_out !== 8'h8B) begin tests_failed++; $display("FAIL x86_ack2_bus got %h expected 8b", data_bus_out); end
    tests_run++; if (data_bus_enable !== 1'b1) begin tests_failed++; $display("FAIL x86_ack2_enable got %b expected 1", data_bus_enable); end
    inta_high();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL x86_end_state got %b expected 000", control_state); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b1) begin tests_failed++; $display("FAIL x86_end_pulse got %b expected 1", end_of_acknowledge_sequence); end
    tests_run++; if (auto_eoi_clear !== 1'b0) begin tests_failed++; $display("FAIL x86_no_eoi got %b expected 0", auto_eoi_clear); end
    tests_run++; if (acknowledge_interrupt !== 8'h08) begin tests_failed++; $display("FAIL x86_latch_hold got %h expected 08", acknowledge_interrupt); end
    tests_run++; if (data_bus_enable !== 1'b0) begin tests_failed++; $display("FAIL x86_idle_enable got %b expected 0", data_bus_enable); end
    tick();
    tests_run++; if (end_of_acknowledge_sequence !== 1'b0) begin tests_failed++; $display("FAIL x86_end_width got %b expected 0", end_of_acknowledge_sequence); end
  endtask

  task automatic test_level_hold();
    highest_request = 8'h01; vector_base = 5'h1F;
    inta_low();
    tick(); tick(); tick();
    tests_run++; if (control_state !== 3'b001) begin tests_failed++; $display("FAIL hold_ack1 got %b expected 001", control_state); end
    inta_high();
    inta_low();
    tick(); tick();
    tests_run++; if (control_state !== 3'b010) begin tests_failed++; $display("FAIL hold_ack2 got %b expected 010", control_state); end
    tests_run++; if (data_bus_out !== 8'hF8) begin tests_failed++; $display("FAIL hold_bus got %h expected f8", data_bus_out); end
    inta_high();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL hold_end got %b expected 000", control_state); end
  endtask

  task automatic test_spurious();
    highest_request = 8'h00; vector_base = 5'h0A;
    inta_low();
    tests_run++; if (acknowledge_interrupt !== 8'h80) begin tests_failed++; $display("FAIL spur_latch got %h expected 80", acknowledge_interrupt); end
    highest_request = 8'h04;
    inta_high();
    inta_low();
    tests_run++; if (acknowledge_interrupt !== 8'h80) begin tests_failed++; $display("FAIL spur_latch_hold got %h expected 80", acknowledge_interrupt); end
    tests_run++; if (data_bus_out !== 8'h57) begin tests_failed++; $display("FAIL spur_bus got %h expected 57", data_bus_out); end
    inta_high();
  endtask

  task automatic test_cascade_block();
    highest_request = 8'h02; vector_base = 5'h02; cascade_output_ack_2_3 = 1'b0;
    inta_low();
    inta_high();
    inta_low();
    tests_run++; if (control_state !== 3'b010) begin tests_failed++; $display("FAIL casc_state got %b expected 010", control_state); end
    tests_run++; if (data_bus_enable !== 1'b0) begin tests_failed++; $display("FAIL casc_enable got %b expected 0", data_bus_enable); end
    tests_run++; if (data_bus_out !== 8'h00) begin tests_failed++; $display("FAIL casc_bus got %h expected 00", data_bus_out); end
    cascade_output_ack_2_3 = 1'b1;
    #1;
    tests_run++; if (data_bus_out !== 8'h11) begin tests_failed++; $display("FAIL casc_grant_bus got %h expected 11", data_bus_out); end
    inta_high();
    tests_run++; if (end_of_acknowledge_sequence !== 1'b1) begin tests_failed++; $display("FAIL casc_end got %b expected 1", end_of_acknowledge_sequence); end
  endtask

  task automatic test_auto_eoi();
    highest_request = 8'h10; vector_base = 5'h05; auto_eoi_config = 1'b1;
    inta_low();
    inta_high();
    inta_low();
    tests_run++; if (auto_eoi_clear !== 1'b0) begin tests_failed++; $display("FAIL aeoi_early got %b expected 0", auto_eoi_clear); end
    inta_high();
    tests_run++; if (auto_eoi_clear !== 1'b1) begin tests_failed++; $display("FAIL aeoi_pulse got %b expected 1", auto_eoi_clear); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b1) begin tests_failed++; $display("FAIL aeoi_end got %b expected 1", end_of_acknowledge_sequence); end
    tick();
    tests_run++; if (auto_eoi_clear !== 1'b0) begin tests_failed++; $display("FAIL aeoi_width got %b expected 0", auto_eoi_clear); end
    auto_eoi_config = 1'b0;
  endtask

  task automatic test_reset_mid();
    highest_request = 8'h20; vector_base = 5'h01;
    inta_low();
    inta_high();
    inta_low();
    tests_run++; if (control_state !== 3'b010) begin tests_failed++; $display("FAIL rst_pre_state got %b expected 010", control_state); end
    reset = 1'b1;
    tick();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_state got %b expected 000", control_state); end
    tests_run++; if (acknowledge_interrupt !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_latch got %h expected 00", acknowledge_interrupt); end
    tests_run++; if (data_bus_enable !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_enable got %b expected 0", data_bus_enable); end
    interrupt_acknowledge_n = 1'b1;
    reset = 1'b0;
    tick();
    tests_run++; if (end_of_acknowledge_sequence !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_end got %b expected 0", end_of_acknowledge_sequence); end
    tests_run++; if (auto_eoi_clear !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_eoi got %b expected 0", auto_eoi_clear); end
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_idle got %b expected 000", control_state); end
    highest_request = 8'h02;
    inta_low();
    tests_run++; if (control_state !== 3'b001) begin tests_failed++; $display("FAIL rst_fresh_state got %b expected 001", control_state); end
    tests_run++; if (acknowledge_interrupt !== 8'h02) begin tests_failed++; $display("FAIL rst_fresh_latch got %h expected 02", acknowledge_interrupt); end
    inta_high();
    inta_low();
    inta_high();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL rst_fresh_end got %b expected 000", control_state); end
  endtask

`ifdef MCS80_MODE_EN
  task automatic test_mcs80();
    highest_request = 8'h20; call_address = 11'h7F5; call_interval_4_config = 1'b1;
    u8086_or_mcs80_config = 1'b0; cascade_output_ack_2_3 = 1'b0;
    inta_low();
    tests_run++; if (data_bus_out !== 8'hCD) begin tests_failed++; $display("FAIL mcs_ack1_bus got %h expected cd", data_bus_out); end
    tests_run++; if (data_bus_enable !== 1'b1) begin tests_failed++; $display("FAIL mcs_ack1_enable got %b expected 1", data_bus_enable); end
    cascade_output_ack_2_3 = 1'b1;
    u8086_or_mcs80_config = 1'b1;
    inta_high();
    inta_low();
    tests_run++; if (data_bus_out !== 8'hB4) begin tests_failed++; $display("FAIL mcs_ack2_bus4 got %h expected b4", data_bus_out); end
    call_interval_4_config = 1'b0;
    #1;
    tests_run++; if (data_bus_out !== 8'hA8) begin tests_failed++; $display("FAIL mcs_ack2_bus8 got %h expected a8", data_bus_out); end
    call_interval_4_config = 1'b1;
    inta_high();
    tests_run++; if (control_state !== 3'b010) begin tests_failed++; $display("FAIL mcs_rise_ack2 got %b expected 010", control_state); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b0) begin tests_failed++; $display("FAIL mcs_no_end_ack2 got %b expected 0", end_of_acknowledge_sequence); end
    inta_low();
    tests_run++; if (control_state !== 3'b011) begin tests_failed++; $display("FAIL mcs_ack3_state got %b expected 011", control_state); end
    tests_run++; if (data_bus_out !== 8'hFE) begin tests_failed++; $display("FAIL mcs_ack3_bus got %h expected fe", data_bus_out); end
    inta_high();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL mcs_end_state got %b expected 000", control_state); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b1) begin tests_failed++; $display("FAIL mcs_end_pulse got %b expected 1", end_of_acknowledge_sequence); end
  endtask
`else
  task automatic test_mode_ignored();
    highest_request = 8'h40; vector_base = 5'h03; u8086_or_mcs80_config = 1'b0;
    call_address = 11'h7F5; cascade_output_ack_2_3 = 1'b1;
    inta_low();
    tests_run++; if (data_bus_enable !== 1'b0) begin tests_failed++; $display("FAIL nomcs_ack1_enable got %b expected 0", data_bus_enable); end
    tests_run++; if (data_bus_out !== 8'h00) begin tests_failed++; $display("FAIL nomcs_ack1_bus got %h expected 00", data_bus_out); end
    inta_high();
    inta_low();
    tests_run++; if (data_bus_out !== 8'h1E) begin tests_failed++; $display("FAIL nomcs_ack2_bus got %h expected 1e", data_bus_out); end
    inta_high();
    tests_run++; if (control_state !== 3'b000) begin tests_failed++; $display("FAIL nomcs_end_state got %b expected 000", control_state); end
    tests_run++; if (end_of_acknowledge_sequence !== 1'b1) begin tests_failed++; $display("FAIL nomcs_end_pulse got %b expected 1", end_of_acknowledge_sequence); end
    u8086_or_mcs80_config = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_8086();
    test_level_hold();
    test_spurious();
    test_cascade_block();
    test_auto_eoi();
    test_reset_mid();
`ifdef MCS80_MODE_EN
    test_mcs80();
`else
    test_mode_ignored();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
